// File: rtl/ser_frame_rx_amisha_pkg.sv
// ser_frame_rx_amisha_pkg: state encoding and default payload width shared by the receiver files.
package ser_frame_rx_amisha_pkg;
  localparam int DATA_W_DEF = 8;
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_DATA   = 3'd1;
  localparam logic [2:0] ST_PARITY = 3'd2;
  localparam logic [2:0] ST_STOP   = 3'd3;
  localparam logic [2:0] ST_BREAK  = 3'd4;
endpackage

// File: rtl/ser_rx_shift_amisha.sv
// ser_rx_shift_amisha: serial-in payload shift register with its bit counter.
module ser_rx_shift_amisha
  import ser_frame_rx_amisha_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk_amisha,
  input  logic              reset_amisha,
  input  logic              clr,
  input  logic              en,
  input  logic              s_in,
  output logic [DATA_W-1:0] data,
  output logic              last
);
  localparam int CW = $clog2(DATA_W + 1);
  logic [CW-1:0] cnt;
  // en is only raised in DATA, so cnt tops out at DATA_W and never wraps
  always_ff @(posedge clk_amisha or posedge reset_amisha)
    if (reset_amisha) begin
      cnt  <= '0;
      data <= '0;
    end else if (clr) cnt <= '0;
    else if (en) begin
      for (int i = 0; i < DATA_W; i++) if (cnt == CW'(i)) data[i] <= s_in;
      cnt <= cnt + 1'b1;
    end
  assign last = cnt == CW'(DATA_W - 1);
endmodule

// File: rtl/ser_frame_rx_amisha.sv
// ser_frame_rx_amisha: start/payload/parity/stop serial frame receiver with registered result pulses.
module ser_frame_rx_amisha
  import ser_frame_rx_amisha_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int PARITY_EN = 0
) (
  input  logic              clk_amisha,
  input  logic              reset_amisha,
  input  logic              s_in_amisha,
  output logic [DATA_W-1:0] d_out_amisha,
  output logic              valid_amisha,
  output logic              frame_err_amisha,
  output logic              parity_err_amisha,
  output logic              busy_amisha
);
  logic [2:0]        state, nxt;
  logic [DATA_W-1:0] payload;
  logic              last, perr;
  ser_rx_shift_amisha #(.DATA_W(DATA_W)) u_shift (
    .clk_amisha  (clk_amisha),
    .reset_amisha(reset_amisha),
    .clr         (state == ST_IDLE && !s_in_amisha),
    .en          (state == ST_DATA),
    .s_in        (s_in_amisha),
    .data        (payload),
    .last        (last)
  );
  always_comb begin
    nxt = ST_IDLE;
    case (state)
      ST_IDLE:           nxt = s_in_amisha ? ST_IDLE : ST_DATA;
      ST_DATA:           nxt = !last ? ST_DATA : PARITY_EN != 0 ? ST_PARITY : ST_STOP;
      ST_PARITY:         nxt = ST_STOP;
      ST_STOP, ST_BREAK: nxt = s_in_amisha ? ST_IDLE : ST_BREAK;
      default:           nxt = ST_IDLE;
    endcase
  end
  // perr is cleared at every frame start so it stays 0 when parity is disabled
  always_ff @(posedge clk_amisha or posedge reset_amisha)
    if (reset_amisha) begin
      state             <= ST_IDLE;
      perr              <= 1'b0;
      d_out_amisha      <= '0;
      valid_amisha      <= 1'b0;
      frame_err_amisha  <= 1'b0;
      parity_err_amisha <= 1'b0;
      busy_amisha       <= 1'b0;
    end else begin
      state             <= nxt;
      busy_amisha       <= nxt != ST_IDLE;
      valid_amisha      <= state == ST_STOP && s_in_amisha && !perr;
      frame_err_amisha  <= state == ST_STOP && !s_in_amisha;
      parity_err_amisha <= state == ST_STOP && perr;
      if (state == ST_STOP && s_in_amisha && !perr) d_out_amisha <= payload;
      perr <= state == ST_IDLE ? 1'b0 : state == ST_PARITY ? ^payload ^ s_in_amisha : perr;
    end
endmodule

// File: doc/ser_frame_rx_amisha.md
SER_FRAME_RX_AMISHA -- requirements
Module: ser_frame_rx_amisha

Interface
REQ-001 Parameter DATA_W, default 8, SHALL set the payload bits per frame; legal range 2..16.
REQ-002 Parameter PARITY_EN, default 0, SHALL insert one even-parity bit after the payload when set to 1.
REQ-003 Port clk_amisha, input, 1 bit, SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 Port reset_amisha, input, 1 bit, SHALL be the reset: asynchronous, active-high.
REQ-005 Port s_in_amisha, input, 1 bit, SHALL carry the serial line, one bit per clock; idle level 1.
REQ-006 Port d_out_amisha, output, DATA_W bits, SHALL hold the last good payload.
REQ-007 Port valid_amisha, output, 1 bit, SHALL be a one-cycle pulse marking a new good payload on d_out_amisha.
REQ-008 Port frame_err_amisha, output, 1 bit, SHALL be a one-cycle pulse for a bad stop bit.
REQ-009 Port parity_err_amisha, output, 1 bit, SHALL be a one-cycle pulse for a parity mismatch.
REQ-010 Port busy_amisha, output, 1 bit, SHALL be 1 in every state except IDLE.

Function
REQ-011 Frame format SHALL be: start bit (0), DATA_W payload bits LSB first, optional parity bit, stop bit (1).
REQ-012 FSM SHALL have states IDLE, DATA, PARITY, STOP, BREAK.
REQ-013 IDLE: s_in_amisha=0 at an edge SHALL move to DATA and clear the bit counter; s_in_amisha=1 SHALL stay in IDLE.
REQ-014 DATA: each edge SHALL shift s_in_amisha into bit position (counter) of the shift register and increment the counter.
REQ-015 DATA: the edge that captures bit DATA_W-1 SHALL move to PARITY if PARITY_EN=1, else to STOP.
REQ-016 PARITY: the edge SHALL capture the parity bit and move to STOP; the error SHALL be recorded if XOR(payload, parity bit) != 0.
REQ-017 STOP with s_in_amisha=1 and no parity error: the edge SHALL load d_out_amisha, pulse valid_amisha in the next cycle and move to IDLE.
REQ-018 STOP with s_in_amisha=1 and a parity error: the edge SHALL pulse parity_err_amisha, SHALL NOT pulse valid_amisha, SHALL leave d_out_amisha unchanged and SHALL move to IDLE.
REQ-019 STOP with s_in_amisha=0: the edge SHALL pulse frame_err_amisha (parity_err_amisha also pulses if parity failed), SHALL leave d_out_amisha unchanged and SHALL move to BREAK.
REQ-020 BREAK SHALL remain until s_in_amisha=1 is sampled, then move to IDLE; a 0 in BREAK SHALL NOT start a frame.
REQ-021 Latency SHALL be 1 clock from the stop-bit sampling edge to the valid/error pulse; all outputs SHALL be registered.
REQ-022 Back-to-back frames SHALL be supported: a start bit sampled on the edge immediately after a good stop bit SHALL be accepted.
REQ-023 valid_amisha, frame_err_amisha and parity_err_amisha SHALL each deassert after exactly one cycle.
REQ-024 Bit counter width SHALL be ceil(log2(DATA_W+1)) and SHALL NOT wrap inside a frame.

Reset
REQ-025 Asserting reset_amisha SHALL immediately force IDLE and clear the counter, shift register, d_out_amisha, valid_amisha, frame_err_amisha, parity_err_amisha and busy_amisha to 0.
REQ-026 Reset asserted mid-frame SHALL abort the frame with no pulse of any kind; reception SHALL restart only on a start bit after reset deasserts.

Structure
REQ-027 A shared package SHALL hold the state encoding constants (IDLE..BREAK) and the DATA_W default.
REQ-028 The serial-in shift register with bit counter SHALL be one sub-module, ser_rx_shift_amisha; the FSM and output registers SHALL stay in the top module.

Verification
REQ-029 Reset, then line 1 for 5 cycles -> busy_amisha=0, all outputs 0.
REQ-030 Frame 0xA5 (0, 1,0,1,0,0,1,0,1, 1), PARITY_EN=0 -> d_out_amisha=0xA5; valid_amisha high for one cycle, 1 clock after the stop edge (edge 10 counting the start as edge 1).
REQ-031 Frames 0x3C then 0xC3 back-to-back with no idle gap -> two valid pulses 10 cycles apart; d_out_amisha=0x3C, then 0xC3.
REQ-032 Frame 0x5A with stop bit 0, then line 0 for 3 cycles, then 1 -> one frame_err_amisha pulse; no valid pulse; d_out_amisha keeps its prior value; FSM returns to IDLE only after the 1.
REQ-033 PARITY_EN=1, frame 0x0F with parity 1 -> one parity_err_amisha pulse, no valid pulse; same frame with parity 0 -> valid_amisha pulse, d_out_amisha=0x0F.
REQ-034 reset_amisha asserted after the 4th payload bit of 0xFF -> all outputs 0 immediately; no pulse; a following frame 0x81 is received correctly.
